ofdm_mod_sched: RTL and testbench

//  Burst sequencer for the TX constellation mappers. Accepts bytes on a WB-style stream and slices them MSB-first

---
 rtl/ofdm_pkg.sv | 47 ++++
 rtl/ofdm_mod_sched_bit_packer.sv | 55 +++++
 rtl/ofdm_mod_sched.sv | 145 ++++++++++++++
 tb/tb_ofdm_mod_sched.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_pkg.sv
// Shared types and helpers for the OFDM TX mapper path: modulation codes,
// sequencer states, chunk payload and bits-per-symbol lookup.
package ofdm_pkg;

  localparam int unsigned NSUB_DEF = 192;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned BUF_W    = 14;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned CHUNK_W  = 6;
  localparam int unsigned K_W      = 3;

  typedef enum logic [1:0] {
    MOD_BPSK  = 2'd0,
    MOD_QPSK  = 2'd1,
    MOD_QAM16 = 2'd2,
    MOD_QAM64 = 2'd3
  } mod_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_PAD   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Registered chunk payload toward the mapper stage
  typedef struct packed {
    logic               sos;
    logic [CHUNK_W-1:0] dat;
  } chunk_t;

  function automatic logic [K_W-1:0] bits_per_sym(input mod_e m);
    case (m)
      MOD_BPSK:  return K_W'(1);
      MOD_QPSK:  return K_W'(2);
      MOD_QAM16: return K_W'(4);
      default:   return K_W'(6);
    endcase
  endfunction

  // Low k bits set, right-aligned in a chunk
  function automatic logic [CHUNK_W-1:0] k_mask(input logic [K_W-1:0] k);
    return CHUNK_W'((7'd1 << k) - 7'd1);
  endfunction

endpackage

// File: rtl/ofdm_mod_sched_bit_packer.sv
// MSB-first bit buffer: loads bytes below the valid bits and releases the top
// K bits per take; bits below the valid region always hold the fill value.
module bit_packer
  import ofdm_pkg::*;
#(
  parameter logic PAD_BIT = 1'b1
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  input  logic [K_W-1:0]     k,
  input  logic               load,
  input  logic [BYTE_W-1:0]  din,
  input  logic               take,
  output logic [CNT_W-1:0]   cnt,
  output logic [CHUNK_W-1:0] chunk_c
);

  localparam logic [BUF_W-1:0] FILL = {BUF_W{PAD_BIT}};

  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BUF_W-1:0] keep_m, din_sh, fill_lo;
  logic [K_W-1:0]   shamt;

  // Next buffer contents; a take below K bits drains to zero, leaving fill behind
  always_comb begin
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    keep_m  = ~({BUF_W{1'b1}} >> cnt_q);
    din_sh  = {din, {(BUF_W-BYTE_W){PAD_BIT}}} >> cnt_q;
    fill_lo = PAD_BIT ? BUF_W'(k_mask(k)) : '0;
    if (load) begin
      buf_d = (buf_q & keep_m) | (din_sh & ~keep_m);
      cnt_d = cnt_q + CNT_W'(BYTE_W);
    end else if (take) begin
      buf_d = (buf_q << k) | fill_lo;
      cnt_d = (cnt_q > CNT_W'(k)) ? cnt_q - CNT_W'(k) : '0;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      buf_q <= FILL;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  assign shamt   = K_W'(CHUNK_W) - k;
  assign chunk_c = buf_q[BUF_W-1 -: CHUNK_W] >> shamt;
  assign cnt     = cnt_q;

endmodule

// File: rtl/ofdm_mod_sched.sv
// Burst sequencer for the TX constellation mappers: slices a byte stream into
// K-bit chunks and pads each burst to whole OFDM symbols of NSUB chunks.
module ofdm_mod_sched
  import ofdm_pkg::*;
#(
  parameter int unsigned NSUB    = NSUB_DEF,
  parameter logic        PAD_BIT = 1'b1
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  input  logic [1:0]         MOD_SEL,
  input  logic [BYTE_W-1:0]  DAT_I,
  input  logic               CYC_I,
  input  logic               STB_I,
  input  logic               WE_I,
  output logic               ACK_O,
  output logic [CHUNK_W-1:0] DAT_O,
  output logic [1:0]         MOD_O,
  output logic               SOS_O,
  output logic               CYC_O,
  output logic               STB_O,
  output logic               WE_O,
  input  logic               ACK_I
);

  localparam int unsigned      SYM_W    = (NSUB > 1) ? $clog2(NSUB) : 1;
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(NSUB - 1);

  state_e             state_q, state_d;
  mod_e               mod_q, mod_d;
  chunk_t             out_q, out_d;
  logic               stb_q, stb_d;
  logic               cyc_q, cyc_d;
  logic [SYM_W-1:0]   sym_q, sym_d;

  logic [K_W-1:0]     k;
  logic [CNT_W-1:0]   cnt;
  logic [CHUNK_W-1:0] chunk_c;
  logic               out_free, halt, load, take, emit_pad;

  assign k        = bits_per_sym(mod_q);
  assign out_free = ~stb_q | ACK_I;
  assign halt     = stb_q & ~ACK_I;
  assign load     = CYC_I & STB_I & WE_I & (state_q == ST_RUN)
                  & (cnt < CNT_W'(k)) & ~halt;

  bit_packer #(
    .PAD_BIT (PAD_BIT)
  ) u_packer (
    .CLK_I   (CLK_I),
    .RST_I   (RST_I),
    .k       (k),
    .load    (load),
    .din     (DAT_I),
    .take    (take),
    .cnt     (cnt),
    .chunk_c (chunk_c)
  );

  // Next state, emit decisions and output register updates
  always_comb begin
    state_d  = state_q;
    mod_d    = mod_q;
    cyc_d    = cyc_q;
    out_d    = out_q;
    stb_d    = stb_q;
    sym_d    = sym_q;
    take     = 1'b0;
    emit_pad = 1'b0;

    // Symbol position advances on each accepted chunk
    if (stb_q && ACK_I) begin
      sym_d     = (sym_q == SYM_LAST) ? '0 : sym_q + SYM_W'(1);
      stb_d     = 1'b0;
      out_d.sos = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (CYC_I) begin
          state_d = ST_RUN;
          mod_d   = mod_e'(MOD_SEL);
          cyc_d   = 1'b1;
          sym_d   = '0;
        end
      end
      ST_RUN: begin
        take = out_free && (cnt >= CNT_W'(k));
        if (!CYC_I) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (out_free) begin
          if (cnt != '0) take = 1'b1;
          else           state_d = ST_PAD;
        end
      end
      ST_PAD: begin
        if (out_free) begin
          if (sym_d != '0) emit_pad = 1'b1;
          else             state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_free) begin
          cyc_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take || emit_pad) begin
      stb_d     = 1'b1;
      out_d.sos = (sym_d == '0);
      out_d.dat = take ? chunk_c : (PAD_BIT ? k_mask(k) : '0);
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= ST_IDLE;
      mod_q   <= MOD_BPSK;
      cyc_q   <= 1'b0;
      out_q   <= '0;
      stb_q   <= 1'b0;
      sym_q   <= '0;
    end else begin
      state_q <= state_d;
      mod_q   <= mod_d;
      cyc_q   <= cyc_d;
      out_q   <= out_d;
      stb_q   <= stb_d;
      sym_q   <= sym_d;
    end
  end

  assign ACK_O = load;
  assign DAT_O = out_q.dat;
  assign SOS_O = out_q.sos;
  assign MOD_O = mod_q;
  assign CYC_O = cyc_q;
  assign STB_O = stb_q;
  assign WE_O  = stb_q;

endmodule

// File: tb/tb_ofdm_mod_sched.sv
// Randomized bench for ofdm_mod_sched with a bit-level burst model and scoreboard.
module tb_ofdm_mod_sched;

  localparam int NSUB = 8;

  logic       CLK_I = 1'b0;
  logic       RST_I;
  logic [1:0] MOD_SEL;
  logic [7:0] DAT_I;
  logic       CYC_I, STB_I, WE_I, ACK_I;
  logic       ACK_O;
  logic [5:0] DAT_O;
  logic [1:0] MOD_O;
  logic       SOS_O, CYC_O, STB_O, WE_O;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  logic [7:0] tx[$];
  bit         ack_always = 1'b0;
  int         stall_req = 0;
  int         xfer_cnt = 0;

  ofdm_mod_sched #(.NSUB(NSUB), .PAD_BIT(1'b1)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .MOD_SEL(MOD_SEL), .DAT_I(DAT_I),
    .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I), .ACK_O(ACK_O),
    .DAT_O(DAT_O), .MOD_O(MOD_O), .SOS_O(SOS_O), .CYC_O(CYC_O),
    .STB_O(STB_O), .WE_O(WE_O), .ACK_I(ACK_I)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int bits_of(input logic [1:0] m);
    case (m)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 6;
    endcase
  endfunction

  // Expected {mod, sos, chunk} stream for the bytes in tx
  task automatic model_burst(input logic [1:0] m);
    int k, nbits, nch, total, b;
    logic [5:0] v;
    logic [7:0] byt;
    logic       bv;
    k     = bits_of(m);
    nbits = tx.size() * 8;
    nch   = (nbits + k - 1) / k;
    total = ((nch + NSUB - 1) / NSUB) * NSUB;
    for (int c = 0; c < total; c++) begin
      v = '0;
      for (int j = 0; j < k; j++) begin
        b = c * k + j;
        if (b < nbits) begin
          byt = tx[b / 8];
          bv  = byt[7 - (b % 8)];
        end else begin
          bv = 1'b1;
        end
        v = {v[4:0], bv};
      end
      exp_q.push_back({m, (c % NSUB) == 0, v});
    end
  endtask

  task automatic monitor();
    logic       held_v;
    logic [8:0] held, obs, e;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge CLK_I);
      if (!RST_I) begin
        ACK_I  = 1'b0;
        held_v = 1'b0;
      end else begin
        if (stall_req > 0) begin
          ACK_I = 1'b0;
          stall_req--;
        end else begin
          ACK_I = ack_always || ($urandom_range(3) != 0);
        end
        #1;
        obs = {MOD_O, SOS_O, DAT_O};
        if (held_v) begin
          check_eq("hold_stb", STB_O, 1);
          check_eq("hold_chunk", obs, held);
        end
        if (STB_O && !ACK_I) check_eq("halt_ack_o", ACK_O, 0);
        if (!(CYC_I && STB_I && WE_I)) check_eq("ack_o_gate", ACK_O, 0);
        if (STB_O && ACK_I) begin
          xfer_cnt++;
          check_eq("we_o", WE_O, 1);
          if (exp_q.size() == 0) check_eq("unexpected_chunk", obs, 32'hDEAD);
          else begin
            e = exp_q.pop_front();
            check_eq("chunk", obs, e);
          end
        end
        held_v = STB_O && !ACK_I;
        held   = obs;
      end
    end
  endtask

  task automatic wait_cyc_o(input logic v, input int budget, input string tag);
    int n;
    n = 0;
    while (CYC_O !== v && n < budget) begin
      @(negedge CLK_I); #2;
      n++;
    end
    check_eq(tag, CYC_O, v);
  endtask

  // Present one byte with random idle and write-disabled cycles until accepted
  task automatic send_byte(input logic [7:0] b);
    int  n, mode;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 400) begin
      @(posedge CLK_I); #1;
      mode = $urandom_range(7);
      if (mode == 0) begin
        STB_I = 1'b0; WE_I = 1'b0; DAT_I = 8'($urandom);
      end else if (mode == 1) begin
        STB_I = 1'b1; WE_I = 1'b0; DAT_I = 8'($urandom);
      end else begin
        STB_I = 1'b1; WE_I = 1'b1; DAT_I = b;
      end
      @(negedge CLK_I); #3;
      if (mode > 1 && ACK_O) done = 1'b1;
      n++;
    end
    check_eq("byte_accept", done, 1);
  endtask

  task automatic drive_burst(input logic [1:0] m, input bit wait_end);
    model_burst(m);
    @(posedge CLK_I); #1;
    MOD_SEL = m; CYC_I = 1'b1; STB_I = 1'b0; WE_I = 1'b0;
    wait_cyc_o(1'b1, 50, "cyc_o_rise");
    check_eq("mod_o_latch", MOD_O, m);
    foreach (tx[i]) begin
      MOD_SEL = 2'($urandom);
      send_byte(tx[i]);
    end
    @(posedge CLK_I); #1;
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    if (wait_end) begin
      wait_cyc_o(1'b0, 4000, "cyc_o_fall");
      check_eq("burst_drained", exp_q.size(), 0);
    end
  endtask

  initial begin
    int  base, n, nb;
    bit  seen_idle, got;
    logic [1:0] m;
    RST_I = 1'b0; MOD_SEL = '0; DAT_I = '0;
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; ACK_I = 1'b0;
    fork monitor(); join_none
    repeat (3) @(negedge CLK_I);
    #2 check_eq("reset_outputs", {DAT_O, MOD_O, SOS_O, CYC_O, STB_O, WE_O, ACK_O}, 0);
    @(negedge CLK_I); #3 RST_I = 1'b1;

    tx = '{8'hFF, 8'h00, 8'hA5}; drive_burst(2'd3, 1'b1);
    tx = '{8'h1B};               drive_burst(2'd1, 1'b1);
    tx = '{8'hC3};               drive_burst(2'd3, 1'b1);
    tx = {};                     drive_burst(2'd2, 1'b1);

    // Downstream stall mid-burst
    ack_always = 1'b1;
    tx = '{8'h3C, 8'h96, 8'hE1, 8'h0F};
    fork
      drive_burst(2'd2, 1'b1);
      begin
        base = xfer_cnt; n = 0;
        while (xfer_cnt < base + 3 && n < 500) begin @(negedge CLK_I); n++; end
        #3 stall_req = 5;
      end
    join
    ack_always = 1'b0;

    // Asynchronous reset in the middle of a BPSK burst
    tx = '{8'hD2}; model_burst(2'd0);
    @(posedge CLK_I); #1 MOD_SEL = 2'd0; CYC_I = 1'b1;
    wait_cyc_o(1'b1, 50, "rst_burst_rise");
    send_byte(8'hD2);
    base = xfer_cnt; n = 0;
    while (xfer_cnt < base + 3 && n < 500) begin @(negedge CLK_I); n++; end
    @(negedge CLK_I); #3 RST_I = 1'b0;
    #1 check_eq("async_reset_outputs", {DAT_O, MOD_O, SOS_O, CYC_O, STB_O, WE_O, ACK_O}, 0);
    exp_q.delete();
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    repeat (2) @(negedge CLK_I);
    #3 RST_I = 1'b1;
    tx = '{8'h80}; drive_burst(2'd0, 1'b1);

    // New burst requested while the previous one is still padding
    tx = '{8'h96}; drive_burst(2'd3, 1'b0);
    tx = '{8'h4D}; model_burst(2'd0);
    @(posedge CLK_I); #1;
    MOD_SEL = 2'd0; CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; DAT_I = 8'h4D;
    seen_idle = 1'b0; got = 1'b0; n = 0;
    while (!got && n < 4000) begin
      @(negedge CLK_I); #3;
      if (!seen_idle) begin
        if (CYC_O) check_eq("early_ack", ACK_O, 0);
        else       seen_idle = 1'b1;
      end else if (ACK_O) begin
        got = 1'b1;
      end
      n++;
    end
    check_eq("burst2_ack", got, 1);
    @(posedge CLK_I); #1 CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    wait_cyc_o(1'b0, 4000, "burst2_fall");
    check_eq("burst2_drained", exp_q.size(), 0);

    // Random bursts
    for (int r = 0; r < 25; r++) begin
      m  = 2'($urandom);
      nb = $urandom_range(5);
      tx = {};
      for (int i = 0; i < nb; i++) tx.push_back(8'($urandom));
      ack_always = ($urandom_range(3) == 0);
      drive_burst(m, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
